alu_muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS datapath. It drives one private `alu32` instance iteratively to execute MULTU/DIVU, one bit per cycle, and writes the HI/LO result pair. It sits beside the main ALU in the execute stage. The core control unit issues work with a start pulse and stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/alu_muldiv_seq_alu32.sv | 39 +++
 rtl/alu_muldiv_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_pkg                                                     |
// | Purpose  : Shared types and constants for the multi-cycle MULTU/DIVU      |
// |            sequencer: FSM state encoding, op codes, alu32 function codes, |
// |            iteration count and the adder carry-out reconstruction.        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  // alu32 exposes no carry, so rebuild it from the operand and sum MSBs:
  // when exactly one operand MSB is set, the carry into bit 31 equals ~s31.
  function automatic logic add_carry(input logic a31, input logic b31,
                                     input logic s31);
    return (a31 & b31) | ((a31 | b31) & ~s31);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_alu32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu32                                                          |
// | Purpose  : 32-bit MIPS ALU. f[2] inverts b and injects a carry-in;        |
// |            f[1:0] selects AND / OR / ADD / SLT.                           |
// | Ports    : a, b  in  32  operands                                         |
// |            f     in  3   function (010 add, 110 subtract)                 |
// |            y     out 32  result                                           |
// |            zero  out 1   result is zero                                   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] y,
  output logic        zero
);

  logic [31:0] b_eff;
  logic [31:0] sum;

  assign b_eff = f[2] ? ~b : b;
  assign sum   = a + b_eff + {31'd0, f[2]};

  always_comb begin
    y = sum;
    case (f[1:0])
      2'b00:   y = a & b_eff;
      2'b01:   y = a | b_eff;
      2'b10:   y = sum;
      default: y = {31'd0, sum[31]};
    endcase
  end

  assign zero = (y == 32'd0);

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_muldiv_seq                                                 |
// | Purpose  : Multi-cycle MULTU/DIVU sequencer; one bit per cycle through a  |
// |            private alu32. Shift-add multiply, restoring divide.           |
// |            Accept -> done latency is a fixed 34 cycles.                   |
// | Ports    : clk, reset_n (async, active low)                               |
// |            start, op[1:0], a, b        request (sampled in IDLE)          |
// |            busy, done, hi, lo          status / result pair               |
// |            div_by_zero                 last divide had b == 0             |
// | Config   : MULDIV_SIGNED_EN - op 10/11 run signed MULT/DIV; when          |
// |            undefined op[1] is ignored and FIX is a pass-through cycle.    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32  // must stay 32: alu32 is fixed width
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  // Working registers are shared between the two algorithms:
  //   wk_hi = acc (MUL) / rem (DIV), wk_lo = mlo / quo, wk_b = mcand / dvs.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wk_hi_q, wk_hi_d;
  logic [WIDTH-1:0] wk_lo_q, wk_lo_d;
  logic [WIDTH-1:0] wk_b_q, wk_b_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
`ifdef MULDIV_SIGNED_EN
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
`else
  logic             unused_op_sign;
  assign unused_op_sign = op[1];
`endif

  logic [31:0]      alu_a, alu_b, alu_y;
  logic [2:0]       alu_f;
  logic             alu_zero_unused;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             carry;

  alu32 u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .f    (alu_f),
    .y    (alu_y),
    .zero (alu_zero_unused)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wk_hi_d  = wk_hi_q;
    wk_lo_d  = wk_lo_q;
    wk_b_d   = wk_b_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_f    = ALU_ADD;
    carry    = 1'b0;
    r_shift  = {wk_hi_q[WIDTH-2:0], wk_lo_q[WIDTH-1]};
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_mag     = (op[1] && a[WIDTH-1]) ? -a : a;
    b_mag     = (op[1] && b[WIDTH-1]) ? -b : b;
`else
    a_mag     = a;
    b_mag     = b;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          cnt_d    = '0;
          is_div_d = op[0];
          wk_hi_d  = '0;
          if (op[0]) begin
            state_d = DIV;
            wk_lo_d = a_mag;
            wk_b_d  = b_mag;
          end else begin
            state_d = MUL;
            wk_lo_d = b_mag;
            wk_b_d  = a_mag;
          end
`ifdef MULDIV_SIGNED_EN
          neg_res_d = op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op[1] & a[WIDTH-1];
`endif
        end
      end

      MUL: begin
        alu_a = wk_hi_q;
        alu_b = wk_b_q;
        alu_f = ALU_ADD;
        carry = add_carry(alu_a[31], alu_b[31], alu_y[31]);
        if (wk_lo_q[0]) begin
          {wk_hi_d, wk_lo_d} = {carry, alu_y, wk_lo_q[WIDTH-1:1]};
        end else begin
          {wk_hi_d, wk_lo_d} = {1'b0, wk_hi_q, wk_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end

      DIV: begin
        alu_a = r_shift;
        alu_b = wk_b_q;
        alu_f = ALU_SUB;
        // carry of a + ~b + 1; a set carry means no borrow (r' >= dvs)
        carry = add_carry(alu_a[31], ~alu_b[31], alu_y[31]);
        // a set rem MSB means the 33-bit shifted remainder already exceeds dvs
        if (wk_hi_q[WIDTH-1] || carry) begin
          wk_hi_d = alu_y;
          wk_lo_d = {wk_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          wk_hi_d = r_shift;
          wk_lo_d = {wk_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end

      FIX: begin
`ifdef MULDIV_SIGNED_EN
        if (is_div_q) begin
          if (neg_res_q) wk_lo_d = -wk_lo_q;
          if (neg_rem_q) wk_hi_d = -wk_hi_q;
        end else if (neg_res_q) begin
          {wk_hi_d, wk_lo_d} = -{wk_hi_q, wk_lo_q};
        end
`endif
        state_d = DONE;
      end

      DONE: begin
        hi_d    = wk_hi_q;
        lo_d    = wk_lo_q;
        done_d  = 1'b1;
        dbz_d   = is_div_q & (wk_b_q == '0);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wk_hi_q   <= '0;
      wk_lo_q   <= '0;
      wk_b_q    <= '0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wk_hi_q   <= wk_hi_d;
      wk_lo_q   <= wk_lo_d;
      wk_b_q    <= wk_b_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_muldiv_seq                                              |
// | Purpose  : Directed self-checking bench for alu_muldiv_seq with           |
// |            hand-computed results, latency, ignored start, async abort.    |
// | Config   : MULDIV_SIGNED_EN selects the signed vectors.                   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Stimulus only: called at a negedge, presents one request, waits (bounded)
  // for done and returns results plus the latency in cycles from the accept
  // edge. Returns one cycle after the done cycle, again at a negedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] rh,
                        output logic [31:0] rl, output logic rdz,
                        output int lat, output logic busy_after);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    rh = hi; rl = lo; rdz = div_by_zero;
    @(posedge clk); @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    n_vec++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    run_op(2'b00, 32'd3, 32'd5, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    n_vec++; if (rh !== 32'h0) begin n_err++; $display("FAIL multu_3x5_hi: got %h expected 00000000", rh); end
    n_vec++; if (rl !== 32'hF) begin n_err++; $display("FAIL multu_3x5_lo: got %h expected 0000000f", rl); end
    n_vec++; if (ba !== 1'b0) begin n_err++; $display("FAIL multu_busy_after: got %b expected 0", ba); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rdz, lat, ba);
    n_vec++; if (rh !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_max_hi: got %h expected fffffffe", rh); end
    n_vec++; if (rl !== 32'h00000001) begin n_err++; $display("FAIL multu_max_lo: got %h expected 00000001", rl); end
    // hi/lo must hold after the done pulse
    n_vec++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hold_hi: got %h expected fffffffe", hi); end
  endtask

  task automatic test_divu();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    run_op(2'b01, 32'd5, 32'd0, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL div0_latency: got %0d expected 34", lat); end
    n_vec++; if (rl !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div0_lo: got %h expected ffffffff", rl); end
    n_vec++; if (rh !== 32'h5) begin n_err++; $display("FAIL div0_hi: got %h expected 00000005", rh); end
    n_vec++; if (rdz !== 1'b1) begin n_err++; $display("FAIL div0_flag: got %b expected 1", rdz); end
    run_op(2'b01, 32'd100, 32'd7, rh, rl, rdz, lat, ba);
    n_vec++; if (rl !== 32'hE) begin n_err++; $display("FAIL divu_lo: got %h expected 0000000e", rl); end
    n_vec++; if (rh !== 32'h2) begin n_err++; $display("FAIL divu_hi: got %h expected 00000002", rh); end
    n_vec++; if (rdz !== 1'b0) begin n_err++; $display("FAIL divu_flag_clear: got %b expected 0", rdz); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    n_vec++; if (rh !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h expected ffffffff", rh); end
    n_vec++; if (rl !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo: got %h expected fffffff1", rl); end
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, rh, rl, rdz, lat, ba);
    n_vec++; if (rl !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h expected fffffffd", rl); end
    n_vec++; if (rh !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h expected ffffffff", rh); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, rh, rl, rdz, lat, ba);
    n_vec++; if (rl !== 32'h80000000) begin n_err++; $display("FAIL div_minint_lo: got %h expected 80000000", rl); end
    n_vec++; if (rh !== 32'h0) begin n_err++; $display("FAIL div_minint_hi: got %h expected 00000000", rh); end
  endtask
`else
  task automatic test_op_sign_ignored();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    // 0xFFFFFFFD * 5 unsigned = 0x4_FFFFFFF1
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL op10_latency: got %0d expected 34", lat); end
    n_vec++; if (rh !== 32'h4) begin n_err++; $display("FAIL op10_hi: got %h expected 00000004", rh); end
    n_vec++; if (rl !== 32'hFFFFFFF1) begin n_err++; $display("FAIL op10_lo: got %h expected fffffff1", rl); end
    // 0xFFFFFFF9 / 2 unsigned = 0x7FFFFFFC rem 1
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, rh, rl, rdz, lat, ba);
    n_vec++; if (rl !== 32'h7FFFFFFC) begin n_err++; $display("FAIL op11_lo: got %h expected 7ffffffc", rl); end
    n_vec++; if (rh !== 32'h1) begin n_err++; $display("FAIL op11_hi: got %h expected 00000001", rh); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    run_op(2'b00, 32'd7, 32'd6, rh, rl, rdz, lat, ba);
    n_vec++; if (rl !== 32'd42) begin n_err++; $display("FAIL b2b_mul_lo: got %h expected 0000002a", rl); end
    run_op(2'b01, 32'hFFFFFFFF, 32'd16, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL b2b_div_latency: got %0d expected 34", lat); end
    n_vec++; if (rl !== 32'h0FFFFFFF) begin n_err++; $display("FAIL b2b_div_lo: got %h expected 0fffffff", rl); end
    n_vec++; if (rh !== 32'hF) begin n_err++; $display("FAIL b2b_div_hi: got %h expected 0000000f", rh); end
  endtask

  task automatic test_ignored_start();
    int lat; int extra;
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b expected 1", busy); end
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); lat++; @(negedge clk);
      if (lat == 10) begin op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1; end
      else start = 1'b0;
    end
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL ign_latency: got %0d expected 34", lat); end
    n_vec++; if (lo !== 32'hE) begin n_err++; $display("FAIL ign_lo: got %h expected 0000000e", lo); end
    n_vec++; if (hi !== 32'h2) begin n_err++; $display("FAIL ign_hi: got %h expected 00000002", hi); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL ign_no_queue: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rh, rl; logic rdz, ba; int lat;
    op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (20) begin @(posedge clk); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd5, rh, rl, rdz, lat, ba);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL post_abort_latency: got %0d expected 34", lat); end
    n_vec++; if (rl !== 32'hF) begin n_err++; $display("FAIL post_abort_lo: got %h expected 0000000f", rl); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`else
    test_op_sign_ignored();
`endif
    test_back_to_back();
    test_ignored_start();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
